// File: rtl/adder_512bit_stream_if.sv
// Bundles the narrow operand input stream and the narrow result output
// stream of the 512-bit streaming adder. The slave modport is the adder
// side; the master modport is the producer/consumer side.
interface adder_512bit_stream_if #(
  parameter int BEAT_W = 64
);
  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic              s_cin;
  logic              m_valid;
  logic              m_ready;
  logic [BEAT_W-1:0] m_data;
  logic              m_last;
  logic              m_cout;

  modport slave (
    input  s_valid, s_data, s_cin, m_ready,
    output s_ready, m_valid, m_data, m_last, m_cout
  );

  modport master (
    output s_valid, s_data, s_cin, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_cout
  );
endinterface

// File: rtl/adder_512bit_stream.sv
// Streaming wrapper around the wide combinational adder: gathers operand A
// and operand B as 64-bit beats (LSB beat first), adds them in one CALC
// cycle, then streams the 512-bit sum back out as 64-bit beats.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready
// are both high. A producer holding valid high while ready is low keeps its
// beat until accepted; this block holds m_data/m_last/m_cout stable while
// m_valid is high and m_ready is low, and never drops m_valid before the
// beat is taken.

// Wide adder built as two chained halves; carry ripples from the low half
// into the high half across the midpoint boundary.
module adder_512bit #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int HALF = WIDTH / 2;

  logic [HALF:0] lo;
  logic [HALF:0] hi;

  assign lo   = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
  assign hi   = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b[WIDTH-1:HALF]} + {{HALF{1'b0}}, lo[HALF]};
  assign sum  = {hi[HALF-1:0], lo[HALF-1:0]};
  assign cout = hi[HALF];
endmodule

module adder_512bit_stream #(
  parameter int WIDTH  = 512,
  parameter int BEAT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_512bit_stream_if.slave  bus,
  output logic                  busy,
  output logic [1:0]            state_dbg
);
  localparam int BEATS = WIDTH / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             cin_q;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             s_hs;
  logic             m_hs;

  assign next_cnt  = beat_cnt + 1'b1;
  assign s_hs      = bus.s_valid && bus.s_ready;
  assign m_hs      = bus.m_valid && bus.m_ready;
  assign state_dbg = state;

  adder_512bit #(.WIDTH(WIDTH)) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (cin_q),
    .sum  (sum),
    .cout (cout)
  );

  // Control FSM with all stream outputs registered; the adder result is
  // captured once in CALC and then walked out beat by beat in SEND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      beat_cnt    <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      cin_q       <= 1'b0;
      bus.s_ready <= 1'b1;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      bus.m_cout  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (s_hs) begin
            op_a[BEAT_W*beat_cnt +: BEAT_W] <= bus.s_data;
            if (beat_cnt == '0) cin_q <= bus.s_cin;
            beat_cnt <= next_cnt;
            busy     <= 1'b1;
            if (beat_cnt == LAST_BEAT) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (s_hs) begin
            op_b[BEAT_W*beat_cnt +: BEAT_W] <= bus.s_data;
            beat_cnt <= next_cnt;
            if (beat_cnt == LAST_BEAT) begin
              state       <= CALC;
              bus.s_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          // beat_cnt is already back at 0 here, so beat 0 of the sum is
          // presented directly from the adder output.
          result      <= sum;
          bus.m_cout  <= cout;
          bus.m_data  <= sum[BEAT_W-1:0];
          bus.m_last  <= (LAST_BEAT == '0);
          bus.m_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (m_hs) begin
            beat_cnt <= next_cnt;
            if (beat_cnt == LAST_BEAT) begin
              state       <= LOAD_A;
              bus.m_valid <= 1'b0;
              bus.m_last  <= 1'b0;
              bus.s_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              bus.m_data <= result[BEAT_W*next_cnt +: BEAT_W];
              bus.m_last <= (next_cnt == LAST_BEAT);
            end
          end
        end
        default: begin
          state    <= LOAD_A;
          beat_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_512bit_stream.sv
// Bench for the 512-bit streaming adder: a vector table of operand sets with
// known sums, a hand-written mid-operation reset sequence, and random
// back-to-back transactions checked against a 513-bit reference addition.
module tb_adder_512bit_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_dbg;

  adder_512bit_stream_if bus ();

  adder_512bit_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic         cin;
    logic [511:0] sum;
    logic         cout;
    int           gap;
    bit           hold;
    bit           stall;
  } vec_t;

  vec_t         vecs[5];
  vec_t         v;
  logic [511:0] ra;
  logic [511:0] rb;
  logic [512:0] ref_sum;

  int           checks     = 0;
  int           errors     = 0;
  logic [65:0]  exp_q[$];
  logic [65:0]  mon_e;
  int           in_hs      = 0;
  int           rx_beat    = 0;
  int           rise_cyc   = -1;
  int           last_b_cyc = 0;
  logic         prev_mv    = 1'b0;
  bit           stall_en   = 1'b0;
  int           stall_cnt  = 0;

  task automatic check1(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [511:0] a, input logic [511:0] b, input logic cin,
                              input logic [511:0] sum, input logic cout, input int gap,
                              input bit hold, input bit stall);
    vec_t r;
    r.a = a; r.b = b; r.cin = cin; r.sum = sum; r.cout = cout;
    r.gap = gap; r.hold = hold; r.stall = stall;
    return r;
  endfunction

  // Scoreboard side: counts accepted input beats, tracks m_valid rise time
  // and compares every accepted (or stalled) result beat with exp_q.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_beat = 0;
    end else begin
      if (bus.s_valid && bus.s_ready) in_hs++;
      if (bus.m_valid && !prev_mv) rise_cyc = cyc;
      if (bus.m_valid) check1("s_ready_low_in_send", bus.s_ready, 0);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check1("result_beat", {bus.m_last, bus.m_cout, bus.m_data}, mon_e);
          rx_beat = bus.m_last ? 0 : rx_beat + 1;
        end
      end else if (bus.m_valid && exp_q.size() != 0) begin
        check1("stall_hold", {bus.m_last, bus.m_cout, bus.m_data}, exp_q[0]);
      end
    end
    prev_mv = bus.m_valid;
  end

  // Downstream ready: normally high; optionally held low 3 cycles on beat 2.
  always @(posedge clk) begin
    #1;
    if (stall_en && rx_beat == 2 && stall_cnt < 3) begin
      bus.m_ready = 1'b0;
      stall_cnt++;
    end else begin
      bus.m_ready = 1'b1;
    end
  end

  // Driver: optional idle gap, then hold one beat until accepted.
  task automatic send_beat(input logic [63:0] d, input logic c, input int max_gap);
    int g;
    int guard;
    g = $urandom_range(0, max_gap);
    repeat (g) begin
      bus.s_valid = 1'b0;
      bus.s_data  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_cin   = c;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL input_accept_timeout: got s_ready 0 expected 1");
        break;
      end
    end
    last_b_cyc = cyc;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t t);
    int base;
    int guard;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, t.cout, t.sum[64*i +: 64]});
    stall_cnt = 0;
    stall_en  = t.stall;
    base      = in_hs;
    for (int i = 0; i < 8; i++) send_beat(t.a[64*i +: 64], (i == 0) ? t.cin : ~t.cin, t.gap);
    for (int i = 0; i < 8; i++) send_beat(t.b[64*i +: 64], ~t.cin, t.gap);
    if (t.hold) begin
      bus.s_valid = 1'b1;
      bus.s_data  = {$urandom, $urandom};
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    check1("latency", rise_cyc - last_b_cyc, 2);
    check1("in_beats_consumed", in_hs - base, 16);
    @(negedge clk);
    check1("idle_m_valid", bus.m_valid, 0);
    check1("cout_hold", bus.m_cout, t.cout);
    check1("busy_idle", busy, 0);
    @(posedge clk); #1;
    stall_en = 1'b0;
  endtask

  // Main sequence.
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_cin   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("rst_s_ready", bus.s_ready, 1);
    check1("rst_m_valid", bus.m_valid, 0);
    check1("rst_m_data", bus.m_data, 0);
    check1("rst_m_last", bus.m_last, 0);
    check1("rst_m_cout", bus.m_cout, 0);
    check1("rst_busy", busy, 0);
    @(posedge clk); #1;

    vecs[0] = mk({512{1'b1}}, '0, 1'b1, '0, 1'b1, 0, 1'b0, 1'b0);
    vecs[1] = mk(512'd5, 512'd7, 1'b1, 512'hD, 1'b0, 0, 1'b0, 1'b0);
    vecs[2] = mk(512'({256{1'b1}}), 512'd1, 1'b0, 512'd1 << 256, 1'b0, 0, 1'b0, 1'b0);
    vecs[3] = mk(512'({256{1'b1}}), 512'd1, 1'b0, 512'd1 << 256, 1'b0, 0, 1'b0, 1'b1);
    vecs[4] = mk({512{1'b1}}, {512{1'b1}}, 1'b1, {512{1'b1}}, 1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset after all of A and 3 beats of B; partial data must be dropped.
    for (int i = 0; i < 8; i++) send_beat({$urandom, $urandom}, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 1'b1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("midrst_s_ready", bus.s_ready, 1);
    check1("midrst_busy", busy, 0);
    check1("midrst_m_valid", bus.m_valid, 0);
    @(posedge clk); #1;
    run_txn(mk(512'd1, 512'd1, 1'b0, 512'd2, 1'b0, 0, 1'b0, 1'b0));

    // Back-to-back random transactions with input gaps and s_valid held
    // high while the result is being returned.
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 16; k++) begin
        ra[32*k +: 32] = $urandom;
        rb[32*k +: 32] = $urandom;
      end
      ref_sum = {1'b0, ra} + {1'b0, rb} + 513'(n[0]);
      v = mk(ra, rb, n[0], ref_sum[511:0], ref_sum[512], 3, 1'b1, 1'b0);
      run_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a wedged run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
